// File: rtl/serial_mod_reduce.sv
// -----------------------------------------------------------------------------
// serial_mod_reduce
//
// Bit-serial modular reducer: R = P mod M, where P is a 2W-bit product and M
// is a W-bit modulus. It uses restoring shift-subtract reduction and folds in
// one product bit per cycle, MSB first. There is a valid/ready handshake on
// both the operand side and the result side.
//
// Ports
//   clock      : rising-edge clock
//   reset      : asynchronous, active-low reset
//   in_valid   : P/M valid (driven by the multiplier's out_valid)
//   in_ready   : block is idle and can accept an operand pair
//   P [2W-1:0] : product to reduce
//   M [W-1:0]  : modulus (unsigned; zero flags err)
//   R [W-1:0]  : P mod M, valid while out_valid
//   err        : the accepted modulus was zero (R is 0)
//   out_valid  : R/err valid; held until out_ready
//   out_ready  : downstream accepts the result
//
// Latency (accept edge to out_valid):
//   - 2W cycles for a full reduction.
//   - 1 cycle for the bypass cases.
//
// Optional build macro
//   SMR_FASTPATH_EN : when P < 2^W and P < M at accept, return P directly
//                     with 1-cycle latency. The result is identical; only
//                     latency changes. A zero modulus still takes priority.
// -----------------------------------------------------------------------------
module serial_mod_reduce #(
  parameter int W = 256
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] P,
  input  logic [W-1:0]   M,
  output logic [W-1:0]   R,
  output logic           err,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int IW = $clog2(2 * W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [2*W-1:0] p_q, p_d;
  logic [W-1:0]   m_q, m_d;
  // The remainder is conceptually W+1 bits wide. Because r < M always holds
  // between iterations, its top bit is always zero, so only W bits are stored.
  logic [W-1:0]   r_q, r_d;
  logic [IW-1:0]  i_q, i_d;
  logic           err_q, err_d;
  // The bypass flag marks a result that is already settled at accept
  // (zero modulus or fast path). RUN then spends one cycle without touching
  // r, which gives those paths their 1-cycle latency.
  logic           byp_q, byp_d;

  // Shifted partial remainder for the current iteration; t < 2M < 2^(W+1).
  logic [W:0]     t;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    m_d     = m_q;
    r_d     = r_q;
    i_d     = i_q;
    err_d   = err_q;
    byp_d   = byp_q;
    t       = {r_q, p_q[i_q]};

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          p_d     = P;
          m_d     = M;
          r_d     = '0;
          i_d     = IW'(2 * W - 1);
          err_d   = 1'b0;
          byp_d   = 1'b0;
          state_d = S_RUN;
          if (M == '0) begin
            err_d = 1'b1;
            byp_d = 1'b1;
          end
`ifdef SMR_FASTPATH_EN
          else if ((P[2*W-1:W] == '0) && (P[W-1:0] < M)) begin
            r_d   = P[W-1:0];
            byp_d = 1'b1;
          end
`endif
        end
      end

      S_RUN: begin
        if (byp_q) begin
          state_d = S_DONE;
        end else begin
          // Restoring step. Whichever branch is taken, the value is below M
          // and therefore fits in W bits.
          r_d = (t >= {1'b0, m_q}) ? W'(t - {1'b0, m_q}) : W'(t);
          if (i_q == '0) begin
            state_d = S_DONE;
          end else begin
            i_d = i_q - IW'(1);
          end
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // updates from the values it held before the edge, with no ordering races.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      i_q     <= '0;
      err_q   <= 1'b0;
      byp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
      r_q     <= r_d;
      i_q     <= i_d;
      err_q   <= err_d;
      byp_q   <= byp_d;
    end
  end

  // All outputs decode flops only; in_valid and out_ready never reach an
  // output combinationally.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign R         = r_q;
  assign err       = err_q;

endmodule

// File: tb/tb_serial_mod_reduce.sv
// -----------------------------------------------------------------------------
// tb_serial_mod_reduce
//
// Scoreboard bench for serial_mod_reduce.
//   - The stimulus process pushes the expected {R, err} for each accepted op.
//   - An independent monitor pops and compares on each out_valid & out_ready.
//   - The reference model uses plain 512-bit modulo arithmetic.
//   - Latency is checked against the cycle counts in the block's contract.
// -----------------------------------------------------------------------------
module tb_serial_mod_reduce;

  localparam int W = 256;

  typedef struct packed {
    logic [W-1:0] r;
    logic         err;
  } exp_t;

  logic           clock;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] P;
  logic [W-1:0]   M;
  logic [W-1:0]   R;
  logic           err;
  logic           out_valid;
  logic           out_ready;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic [2*W-1:0] tp, ga, gb;
  logic [W-1:0]   tm, saved_r;
  logic           saved_err;

  serial_mod_reduce #(.W(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .P        (P),
    .M        (M),
    .R        (R),
    .err      (err),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Global time bound, far beyond the expected run length.
  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, required finish before %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the whole product.
  function automatic logic [W-1:0] ref_mod(input logic [2*W-1:0] p, input logic [W-1:0] m);
    logic [2*W-1:0] mm;
    if (m == '0) return '0;
    mm = {{W{1'b0}}, m};
    return W'(p % mm);
  endfunction

  function automatic int exp_lat(input logic [2*W-1:0] p, input logic [W-1:0] m);
    if (m == '0) return 1;
`ifdef SMR_FASTPATH_EN
    if ((p[2*W-1:W] == '0) && (p[W-1:0] < m)) return 1;
`endif
    return 2 * W;
  endfunction

  function automatic logic [2*W-1:0] rand_p();
    logic [2*W-1:0] v;
    for (int k = 0; k < 2 * W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [W-1:0] rand_m();
    logic [W-1:0] v;
    for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic push_exp(input logic [2*W-1:0] p, input logic [W-1:0] m);
    exp_t e;
    e.r   = ref_mod(p, m);
    e.err = (m == '0);
    sb.push_back(e);
  endtask

  // Waits (bounded) for in_ready, then presents one operand pair for exactly
  // the accept edge. Returns at accept edge + 1 time unit.
  task automatic issue(input logic [2*W-1:0] p, input logic [W-1:0] m, input bit push);
    int n = 0;
    while (!in_ready && n < 2000) begin
      @(posedge clock); #1; n++;
    end
    if (!in_ready) check("in_ready_timeout", W'(in_ready), W'(1));
    P        = p;
    M        = m;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    if (push) push_exp(p, m);
  endtask

  // Counts edges after the accept edge until out_valid shows.
  task automatic wait_out(input string name, input int exp);
    int lat = 0;
    while (!out_valid && lat < 2 * W + 50) begin
      @(posedge clock); #1; lat++;
    end
    check({name, "_latency"}, W'(lat), W'(exp));
  endtask

  task automatic do_op(input string name, input logic [2*W-1:0] p, input logic [W-1:0] m);
    issue(p, m, 1'b1);
    wait_out(name, exp_lat(p, m));
  endtask

  // Monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got R=%h err=%b, required no result", R, err);
      end else begin
        mon_e = sb.pop_front();
        check("result_R", R, mon_e.r);
        check("result_err", W'(err), W'(mon_e.err));
      end
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    P         = '0;
    M         = '0;
    #2 reset = 1'b0;
    #2;
    check("reset_in_ready", W'(in_ready), W'(1));
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_R", R, '0);
    check("reset_err", W'(err), W'(0));
    @(negedge clock) reset = 1'b1;

    // Basic and small-operand cases.
    do_op("basic_100_mod_7", 2*W'(100), W'(7));
    do_op("small_5_mod_7", 2*W'(5), W'(7));

    // Golden product against the modulus 2^255-19.
    ga = {{W{1'b0}}, {4{64'h123456789ABCDEF0}}};
    gb = {{W{1'b0}}, {4{64'hFEDCBA9876543210}}};
    tm = (W'(1) << 255) - W'(19);
    do_op("golden", ga * gb, tm);

    // Edge values.
    do_op("all_ones_mod_max", '1, '1);
    do_op("all_ones_mod_1", '1, W'(1));

    // Zero modulus: 1-cycle latency, and err clears on release.
    do_op("zero_modulus", (2*W)'(1) << (2 * W - 1), '0);
    @(posedge clock); #1;
    check("err_cleared", W'(err), W'(0));
    check("zero_mod_released", W'(out_valid), W'(0));

    // Back-pressure: the result must stay frozen while inputs churn.
    out_ready = 1'b0;
    tp = rand_p();
    tm = rand_m() | (W'(1) << (W - 1));
    do_op("backpressure", tp, tm);
    saved_r   = R;
    saved_err = err;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      P        = rand_p();
      M        = rand_m();
      @(posedge clock); #1;
      check("bp_R_stable", R, saved_r);
      check("bp_err_stable", W'(err), W'(saved_err));
      check("bp_out_valid", W'(out_valid), W'(1));
      check("bp_in_ready", W'(in_ready), W'(0));
    end
    in_valid  = 1'b1;
    P         = 2*W'(100);
    M         = W'(7);
    out_ready = 1'b1;
    @(posedge clock); #1;  // release edge
    check("release_in_ready", W'(in_ready), W'(1));
    check("release_out_valid", W'(out_valid), W'(0));
    @(posedge clock); #1;  // accept edge
    check("accept_after_release", W'(in_ready), W'(0));
    in_valid = 1'b0;
    push_exp(2*W'(100), W'(7));
    wait_out("post_release", exp_lat(2*W'(100), W'(7)));

    // Randomized operations, including small moduli and operands below M.
    for (int k = 0; k < 6; k++) begin
      tp = rand_p();
      tm = rand_m();
      if (k == 0) tm = W'($urandom_range(1, 1000));
      if (k == 1) tp = {{W{1'b0}}, tm - W'(1)};
      if (k == 2) tm = tm | (W'(1) << (W - 1));
      if (tm == '0) tm = W'(3);
      do_op("random", tp, tm);
    end

    // Asynchronous reset in the middle of RUN.
    tp = rand_p() | ((2*W)'(1) << (2 * W - 1));
    tm = rand_m() | W'(1);
    issue(tp, tm, 1'b0);
    repeat (200) begin
      @(posedge clock); #1;
    end
    reset = 1'b0;
    #1;
    check("midrun_reset_out_valid", W'(out_valid), W'(0));
    check("midrun_reset_in_ready", W'(in_ready), W'(1));
    check("midrun_reset_R", R, '0);
    check("midrun_reset_err", W'(err), W'(0));
    @(negedge clock) reset = 1'b1;
    do_op("after_reset_100_mod_7", 2*W'(100), W'(7));

    repeat (3) @(posedge clock);
    #1;
    check("scoreboard_drained", W'(sb.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
